// File: rtl/nrisc_pkg.sv
// Shared types and constants for the nRISC memory arbiter slice.
// Holds FSM/grant enums, default widths and the latency counter width.
package nrisc_pkg;

  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_W       = $clog2(MEM_LAT_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF   = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  // Round-robin pick: on a tie the source not served last wins.
  function automatic grant_t pick_grant(input logic if_req, input logic d_req,
                                        input grant_t last_grant);
    if (if_req && d_req)
      return (last_grant == GRANT_IF) ? GRANT_DATA : GRANT_IF;
    else if (if_req)
      return GRANT_IF;
    else
      return GRANT_DATA;
  endfunction

endpackage

// File: rtl/nrisc_mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// slave = arbiter view, master = core + memory view.
interface nrisc_mem_arbiter_if
  import nrisc_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/nrisc_lat_counter.sv
// Loadable down-counter timing the memory read latency; last is high
// in the final cycle of the count.
module nrisc_lat_counter
  import nrisc_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);
  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load)
      cnt_next = load_val;
    else if (dec && (cnt_reg != '0))
      cnt_next = cnt_reg - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign last = (cnt_reg == W'(1));
endmodule

// File: rtl/nrisc_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction
// fetch and load/store, with a stall output for the core's halt input.
module nrisc_mem_arbiter
  import nrisc_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  nrisc_mem_arbiter_if.slave  bus
);
  arb_state_t    state_reg, state_next;
  grant_t        grant_reg, grant_next;
  grant_t        last_grant_reg, last_grant_next;
  logic [AW-1:0] addr_reg;
  logic          we_reg;
  logic [DW-1:0] wdata_reg;

  logic latch_en, cnt_load, cnt_dec, cnt_last, capture;
  logic mem_en, mem_we, if_ack, d_ack;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    latch_en        = 1'b0;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;
    capture         = 1'b0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    if_ack          = 1'b0;
    d_ack           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant_next = pick_grant(bus.if_req, bus.d_req, last_grant_reg);
          latch_en   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_en = 1'b1;
        mem_we = we_reg;
        if (we_reg) begin
          state_next = RESP;
        end else begin
          cnt_load   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if_ack          = (grant_reg == GRANT_IF);
        d_ack           = (grant_reg == GRANT_DATA);
        last_grant_next = grant_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_reg      <= IDLE;
      grant_reg      <= GRANT_IF;
      last_grant_reg <= GRANT_DATA;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      if (latch_en) begin
        addr_reg <= (grant_next == GRANT_IF) ? bus.if_addr : bus.d_addr;
        we_reg   <= (grant_next == GRANT_DATA) && bus.d_we;
        // Fetches carry no write data, so the store data register is left alone.
        if (grant_next == GRANT_DATA)
          wdata_reg <= bus.d_wdata;
      end
    end
  end

  nrisc_lat_counter #(.W(LAT_W)) u_lat_counter (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .load     (cnt_load),
    .load_val (LAT_W'(MEM_LAT)),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // One read-data register per source; index matches the grant_t encoding.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [DW-1:0] rdata_reg;
      always_ff @(posedge Clock) begin
        if (!Reset_n)
          rdata_reg <= '0;
        else if (capture && (int'(grant_reg) == gi))
          rdata_reg <= bus.mem_rdata;
      end
    end
  endgenerate

  assign bus.if_ack    = if_ack;
  assign bus.d_ack     = d_ack;
  assign bus.if_rdata  = g_src[0].rdata_reg;
  assign bus.d_rdata   = g_src[1].rdata_reg;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.stall     = (bus.if_req & ~if_ack) | (bus.d_req & ~d_ack);
endmodule

// File: tb/tb_nrisc_mem_arbiter.sv
// Bench for nrisc_mem_arbiter: two instances (MEM_LAT 1 and 4) driven by
// directed requesters and checked every cycle against a transaction model.
module tb_nrisc_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nrisc_mem_arbiter_if #(.AW(8), .DW(8)) bus0 ();
  nrisc_mem_arbiter_if #(.AW(8), .DW(8)) bus1 ();

  nrisc_mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(1)) u_dut_l1 (
    .Clock(clk), .Reset_n(rst_n), .bus(bus0));
  nrisc_mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(4)) u_dut_l4 (
    .Clock(clk), .Reset_n(rst_n), .bus(bus1));

  logic       if_req_a [2];
  logic [7:0] if_addr_a [2];
  logic       d_req_a [2];
  logic       d_we_a [2];
  logic [7:0] d_addr_a [2];
  logic [7:0] d_wdata_a [2];
  logic       if_ack_a [2], d_ack_a [2], mem_en_a [2], mem_we_a [2], stall_a [2];
  logic [7:0] if_rdata_a [2], d_rdata_a [2], mem_addr_a [2], mem_wdata_a [2];
  logic [7:0] mem_rdata_a [2];

  assign bus0.if_req = if_req_a[0];   assign bus1.if_req = if_req_a[1];
  assign bus0.if_addr = if_addr_a[0]; assign bus1.if_addr = if_addr_a[1];
  assign bus0.d_req = d_req_a[0];     assign bus1.d_req = d_req_a[1];
  assign bus0.d_we = d_we_a[0];       assign bus1.d_we = d_we_a[1];
  assign bus0.d_addr = d_addr_a[0];   assign bus1.d_addr = d_addr_a[1];
  assign bus0.d_wdata = d_wdata_a[0]; assign bus1.d_wdata = d_wdata_a[1];
  assign bus0.mem_rdata = mem_rdata_a[0];
  assign bus1.mem_rdata = mem_rdata_a[1];

  assign if_ack_a[0] = bus0.if_ack;       assign if_ack_a[1] = bus1.if_ack;
  assign d_ack_a[0] = bus0.d_ack;         assign d_ack_a[1] = bus1.d_ack;
  assign mem_en_a[0] = bus0.mem_en;       assign mem_en_a[1] = bus1.mem_en;
  assign mem_we_a[0] = bus0.mem_we;       assign mem_we_a[1] = bus1.mem_we;
  assign stall_a[0] = bus0.stall;         assign stall_a[1] = bus1.stall;
  assign if_rdata_a[0] = bus0.if_rdata;   assign if_rdata_a[1] = bus1.if_rdata;
  assign d_rdata_a[0] = bus0.d_rdata;     assign d_rdata_a[1] = bus1.d_rdata;
  assign mem_addr_a[0] = bus0.mem_addr;   assign mem_addr_a[1] = bus1.mem_addr;
  assign mem_wdata_a[0] = bus0.mem_wdata; assign mem_wdata_a[1] = bus1.mem_wdata;

  // Memory behind each instance: data appears exactly MEM_LAT cycles after mem_en.
  logic [7:0] dmem [2][256];
  logic [7:0] pipe0;
  logic [7:0] pipe1 [4];
  assign mem_rdata_a[0] = pipe0;
  assign mem_rdata_a[1] = pipe1[3];

  always @(posedge clk) begin
    if (mem_en_a[0] === 1'b1 && mem_we_a[0] === 1'b1) dmem[0][mem_addr_a[0]] = mem_wdata_a[0];
    if (mem_en_a[1] === 1'b1 && mem_we_a[1] === 1'b1) dmem[1][mem_addr_a[1]] = mem_wdata_a[1];
    pipe0 <= (mem_en_a[0] === 1'b1 && mem_we_a[0] === 1'b0) ? dmem[0][mem_addr_a[0]] : 8'hEE;
    pipe1[0] <= (mem_en_a[1] === 1'b1 && mem_we_a[1] === 1'b0) ? dmem[1][mem_addr_a[1]] : 8'hEE;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
    pipe1[3] <= pipe1[2];
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h, expected %0h (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  // Transaction-level model: phase = cycles since the IDLE cycle that granted.
  bit         m_valid [2], m_busy [2], m_src [2], m_wr [2], m_last [2], m_wknown [2];
  int         m_ph [2];
  logic [7:0] m_addr [2], m_wdata [2];
  logic [7:0] m_rd [2][2];
  logic [7:0] mmem [2][256];
  int         ord_q [2][$];

  task automatic model_step(input int i);
    int   lat, ack_ph;
    logic e_en, e_we, e_ia, e_da, e_stall;
    lat    = (i == 0) ? 1 : 4;
    ack_ph = m_wr[i] ? 2 : 2 + lat;
    if (m_valid[i]) begin
      e_en = 1'b0; e_we = 1'b0; e_ia = 1'b0; e_da = 1'b0;
      if (m_busy[i]) begin
        if (m_ph[i] == 1) begin e_en = 1'b1; e_we = m_wr[i]; end
        if (m_ph[i] == ack_ph) begin
          if (m_src[i]) e_da = 1'b1; else e_ia = 1'b1;
        end
      end
      e_stall = (if_req_a[i] & ~e_ia) | (d_req_a[i] & ~e_da);
      chk("mem_en", i, mem_en_a[i], e_en);
      chk("mem_we", i, mem_we_a[i], e_we);
      chk("mem_addr", i, mem_addr_a[i], m_addr[i]);
      if (m_wknown[i]) chk("mem_wdata", i, mem_wdata_a[i], m_wdata[i]);
      chk("if_ack", i, if_ack_a[i], e_ia);
      chk("d_ack", i, d_ack_a[i], e_da);
      chk("if_rdata", i, if_rdata_a[i], m_rd[i][0]);
      chk("d_rdata", i, d_rdata_a[i], m_rd[i][1]);
      chk("stall", i, stall_a[i], e_stall);
    end
    if (rst_n === 1'b0) begin
      m_valid[i] = 1; m_busy[i] = 0; m_ph[i] = 0; m_last[i] = 1; m_wr[i] = 0;
      m_addr[i] = 8'h00; m_wdata[i] = 8'h00; m_wknown[i] = 1;
      m_rd[i][0] = 8'h00; m_rd[i][1] = 8'h00;
    end else if (m_valid[i]) begin
      if (!m_busy[i]) begin
        if (if_req_a[i] || d_req_a[i]) begin
          m_src[i]  = (if_req_a[i] && d_req_a[i]) ? ~m_last[i] : d_req_a[i];
          m_busy[i] = 1;
          m_ph[i]   = 1;
          if (m_src[i]) begin
            m_wr[i] = d_we_a[i]; m_addr[i] = d_addr_a[i];
            m_wdata[i] = d_wdata_a[i]; m_wknown[i] = 1;
          end else begin
            m_wr[i] = 0; m_addr[i] = if_addr_a[i]; m_wknown[i] = 0;
          end
        end
      end else begin
        if (m_ph[i] == 1 && m_wr[i]) mmem[i][m_addr[i]] = m_wdata[i];
        if (!m_wr[i] && m_ph[i] == 1 + lat) m_rd[i][m_src[i]] = mmem[i][m_addr[i]];
        if (m_ph[i] == ack_ph) begin m_busy[i] = 0; m_last[i] = m_src[i]; end
        else m_ph[i]++;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      model_step(i);
      if (if_ack_a[i] === 1'b1) ord_q[i].push_back(0);
      if (d_ack_a[i] === 1'b1) ord_q[i].push_back(1);
    end
  end

  task automatic fetch_txn(input int i, input logic [7:0] a, input bit keep,
                           output int off, output logic [7:0] rd);
    int start; bit got;
    @(posedge clk); #1;
    if_req_a[i] = 1'b1; if_addr_a[i] = a; start = cyc; got = 0; off = -1; rd = 8'h00;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (if_ack_a[i] === 1'b1) begin got = 1; off = cyc - start; rd = if_rdata_a[i]; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL fetch_timeout inst%0d: got no if_ack, expected one within 60 cycles", i);
    end
    $display("txn inst%0d fetch addr=%02h ack_cycle=%0d rdata=%02h", i, a, off, rd);
    if (!keep) begin @(posedge clk); #1; if_req_a[i] = 1'b0; end
  endtask

  task automatic data_txn(input int i, input logic we, input logic [7:0] a,
                          input logic [7:0] wd, input bit keep,
                          output int off, output logic [7:0] rd);
    int start; bit got;
    @(posedge clk); #1;
    d_req_a[i] = 1'b1; d_we_a[i] = we; d_addr_a[i] = a; d_wdata_a[i] = wd;
    start = cyc; got = 0; off = -1; rd = 8'h00;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (d_ack_a[i] === 1'b1) begin got = 1; off = cyc - start; rd = d_rdata_a[i]; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL data_timeout inst%0d: got no d_ack, expected one within 60 cycles", i);
    end
    $display("txn inst%0d %s addr=%02h wdata=%02h ack_cycle=%0d rdata=%02h",
             i, we ? "store" : "load", a, wd, off, rd);
    if (!keep) begin @(posedge clk); #1; d_req_a[i] = 1'b0; end
  endtask

  int         off_if [2], off_d [2], dum_off [4];
  logic [7:0] rd_if [2], rd_d [2], dum_rd [4];
  int         rr_code;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected one before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      if_req_a[i] = 0; if_addr_a[i] = 0; d_req_a[i] = 0; d_we_a[i] = 0;
      d_addr_a[i] = 0; d_wdata_a[i] = 0;
      for (int a = 0; a < 256; a++) begin
        dmem[i][a] = 8'(a) ^ 8'h5A;
        mmem[i][a] = 8'(a) ^ 8'h5A;
      end
      dmem[i][8'h10] = 8'hA5; mmem[i][8'h10] = 8'hA5;
      dmem[i][8'h05] = 8'h7E; mmem[i][8'h05] = 8'h7E;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_mem_en", i, mem_en_a[i], 1'b0);
      chk("rst_mem_addr", i, mem_addr_a[i], 8'h00);
      chk("rst_if_rdata", i, if_rdata_a[i], 8'h00);
      chk("rst_d_rdata", i, d_rdata_a[i], 8'h00);
    end

    // Fetch only
    fork
      fetch_txn(0, 8'h10, 0, off_if[0], rd_if[0]);
      fetch_txn(1, 8'h10, 0, off_if[1], rd_if[1]);
    join
    chk("fetch_ack_cycle", 0, off_if[0], 3);
    chk("fetch_ack_cycle", 1, off_if[1], 6);
    chk("fetch_rdata", 0, rd_if[0], 8'hA5);
    chk("fetch_rdata", 1, rd_if[1], 8'hA5);

    // Store only
    fork
      data_txn(0, 1'b1, 8'h20, 8'h3C, 0, off_d[0], rd_d[0]);
      data_txn(1, 1'b1, 8'h20, 8'h3C, 0, off_d[1], rd_d[1]);
    join
    chk("store_ack_cycle", 0, off_d[0], 2);
    chk("store_ack_cycle", 1, off_d[1], 2);

    // Simultaneous fetch and load: fetch wins, load follows
    fork
      fetch_txn(0, 8'h11, 0, off_if[0], rd_if[0]);
      data_txn(0, 1'b0, 8'h05, 8'h00, 0, off_d[0], rd_d[0]);
      fetch_txn(1, 8'h11, 0, off_if[1], rd_if[1]);
      data_txn(1, 1'b0, 8'h05, 8'h00, 0, off_d[1], rd_d[1]);
    join
    chk("simul_if_cycle", 0, off_if[0], 3);
    chk("simul_if_cycle", 1, off_if[1], 6);
    chk("simul_d_cycle", 0, off_d[0], 7);
    chk("simul_d_cycle", 1, off_d[1], 13);
    chk("simul_if_rdata", 0, rd_if[0], 8'h4B);
    chk("simul_d_rdata", 1, rd_d[1], 8'h7E);

    // Round-robin with both sources held continuously
    ord_q[0].delete(); ord_q[1].delete();
    fork
      begin fetch_txn(0, 8'h30, 1, dum_off[0], dum_rd[0]); fetch_txn(0, 8'h31, 0, off_if[0], rd_if[0]); end
      begin data_txn(0, 1'b1, 8'h40, 8'h99, 1, dum_off[1], dum_rd[1]); data_txn(0, 1'b0, 8'h40, 8'h00, 0, off_d[0], rd_d[0]); end
      begin fetch_txn(1, 8'h30, 1, dum_off[2], dum_rd[2]); fetch_txn(1, 8'h31, 0, off_if[1], rd_if[1]); end
      begin data_txn(1, 1'b1, 8'h40, 8'h99, 1, dum_off[3], dum_rd[3]); data_txn(1, 1'b0, 8'h40, 8'h00, 0, off_d[1], rd_d[1]); end
    join
    for (int i = 0; i < 2; i++) begin
      chk("rr_count", i, ord_q[i].size(), 4);
      rr_code = 0;
      foreach (ord_q[i][k]) rr_code = rr_code * 2 + ord_q[i][k];
      chk("rr_order", i, rr_code, 32'h5);
      chk("rr_if_rdata", i, rd_if[i], 8'h6B);
      chk("rr_d_rdata", i, rd_d[i], 8'h99);
    end

    // Load alone, then fetch of stored byte (leaves last grant on fetch)
    fork
      data_txn(0, 1'b0, 8'h05, 8'h00, 0, off_d[0], rd_d[0]);
      data_txn(1, 1'b0, 8'h05, 8'h00, 0, off_d[1], rd_d[1]);
    join
    chk("load_ack_cycle", 0, off_d[0], 3);
    chk("load_ack_cycle", 1, off_d[1], 6);
    chk("load_rdata", 1, rd_d[1], 8'h7E);
    fork
      fetch_txn(0, 8'h20, 0, off_if[0], rd_if[0]);
      fetch_txn(1, 8'h20, 0, off_if[1], rd_if[1]);
    join
    chk("fetch_stored", 0, rd_if[0], 8'h3C);
    chk("fetch_stored", 1, rd_if[1], 8'h3C);

    // Reset during the WAIT phase of a load
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      d_req_a[i] = 1'b1; d_we_a[i] = 1'b0; d_addr_a[i] = 8'h05;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) d_req_a[i] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ord_q[0].delete(); ord_q[1].delete();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("midrst_d_ack", i, d_ack_a[i], 1'b0);
      chk("midrst_d_rdata", i, d_rdata_a[i], 8'h00);
      chk("midrst_if_rdata", i, if_rdata_a[i], 8'h00);
    end
    repeat (10) @(negedge clk);
    chk("midrst_no_ack", 0, ord_q[0].size(), 0);
    chk("midrst_no_ack", 1, ord_q[1].size(), 0);

    // After reset, a tie goes to fetch first
    fork
      fetch_txn(0, 8'h10, 0, off_if[0], rd_if[0]);
      data_txn(0, 1'b0, 8'h20, 8'h00, 0, off_d[0], rd_d[0]);
      fetch_txn(1, 8'h10, 0, off_if[1], rd_if[1]);
      data_txn(1, 1'b0, 8'h20, 8'h00, 0, off_d[1], rd_d[1]);
    join
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_first", i, (ord_q[i].size() > 0) ? ord_q[i][0] : 9, 0);
      chk("post_rst_d_rdata", i, rd_d[i], 8'h3C);
    end
    chk("post_rst_d_cycle", 0, off_d[0], 7);
    chk("post_rst_d_cycle", 1, off_d[1], 13);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nrisc_mem_arbiter.md
Name: nrisc_mem_arbiter

Overview:
- Shares one single-port 8-bit memory between the core's instruction-fetch path and its load/store path.
- Accepts level-held requests from both and arbitrates them round-robin.
- Sequences each memory access through a small FSM and returns a one-cycle ack pulse with registered read data.
- Drives a stall output that feeds the core's halt input, freezing PC and register bank while an access is outstanding.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..4.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  AW  fetch address (PC); stable while if_req high.
- if_ack  out  1  one-cycle pulse; if_rdata valid in that cycle.
- if_rdata  out  DW  fetched instruction byte, registered.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req high.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle pulse completing the data access.
- d_rdata  out  DW  load data, registered.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.
- stall  out  1  (if_req & ~if_ack) | (d_req & ~d_ack), combinational.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the source not granted last; the last_grant register resets to DATA, so fetch wins first.
  - On grant: latch addr, we and wdata into internal registers, record the grant, go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1; mem_addr, mem_we and mem_wdata come from the latched registers.
  - Write: go to RESP.
  - Read: go to WAIT and load the latency counter with MEM_LAT.
- WAIT (MEM_LAT cycles):
  - Counter decrements each cycle.
  - On the last WAIT cycle, capture mem_rdata into the granted source's rdata register, then go to RESP.
- RESP (1 cycle): assert the granted source's ack, update last_grant, go to IDLE.
- Latency, request sampled in IDLE at cycle T:
  - mem_en in cycle T+1.
  - Read ack in cycle T+2+MEM_LAT.
  - Write ack in cycle T+2.
- Back-to-back: minimum transaction period is MEM_LAT+3 cycles for a read, 3 for a write.
- Requester protocol:
  - The requester deasserts req in the cycle after ack unless it issues a new request.
  - A req still high in the IDLE cycle after ack is a new request.
- Request dropped before ack: the transaction still completes and the ack pulse is still issued; no abort.
- Outputs outside active states:
  - mem_en=0, mem_we=0 in IDLE, WAIT and RESP.
  - mem_addr and mem_wdata hold their latched values.
- Reset (Reset_n=0 at a rising edge, any state including mid-transaction):
  - state=IDLE, last_grant=DATA.
  - if_ack=d_ack=mem_en=mem_we=0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0; counter=0.
  - An in-flight access is abandoned with no ack.
  - stall stays combinational and reflects the requests during reset.
- if_rdata and d_rdata hold their last captured value until the next read for that source.
- Address arithmetic: none; addresses pass through unmodified at AW bits.

Decomposition:
- Shared package nrisc_pkg holds:
  - The state enum (IDLE, ISSUE, WAIT, RESP).
  - The grant enum (GRANT_IF, GRANT_DATA).
  - Default AW/DW constants.
  - A localparam for the MEM_LAT counter width, clog2(4)+1 = 3 bits.
- One natural sub-module, nrisc_lat_counter: a loadable down-counter with a "last" flag used in WAIT.

Test Plan:
- Fetch only, MEM_LAT=1: if_req=1, if_addr=0x10 at cycle 0, mem returns 0xA5 → mem_en=1 with mem_addr=0x10 in cycle 1; if_ack=1, if_rdata=0xA5 in cycle 3; stall=1 in cycles 0–2 and 0 in cycle 3.
- Store only: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x3C at cycle 0 → mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x3C in cycle 1; d_ack in cycle 2; no WAIT cycle.
- Simultaneous after reset, MEM_LAT=1: if_req and a d_req load both at cycle 0, both held until ack → fetch acked at cycle 3; data mem_en at cycle 5; d_ack at cycle 7.
- Round-robin fairness: both requests held continuously for 4 grants → grant order is IF, DATA, IF, DATA; neither source starves.
- MEM_LAT=4 load: d_addr=0x05 returning 0x7E → mem_en in cycle 1, four WAIT cycles, d_ack with d_rdata=0x7E in cycle 6.
- Reset mid-WAIT: Reset_n=0 during cycle 2 of a MEM_LAT=4 read → next cycle state=IDLE, all acks 0, rdata registers 0; no ack ever issued for that transaction; the arbiter grants fetch first after Reset_n returns to 1.
